// File: rtl/rx_ack_nak_scheduler.sv
// Receive-side data link sequencing: tracks NEXT_RCV_SEQ, classifies incoming
// TLPs as good / duplicate / bad-or-lost, and schedules Ack/Nak DLLPs into a
// single outbound slot that is shared with Transaction-Layer UpdateFC requests.
module rx_ack_nak_scheduler #(
  parameter int ACK_LATENCY  = 64,
  parameter int ACK_COALESCE = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        rx_tlp_valid,
  input  logic        rx_tlp_lcrc_ok,
  input  logic [11:0] rx_tlp_seq,
  output logic        rx_tlp_accept,
  output logic        rx_tlp_drop,
  input  logic        fc_req_valid,
  input  logic [31:0] fc_req_dllp,
  output logic        fc_req_ready,
  output logic        dllp_valid,
  output logic [31:0] dllp,
  input  logic        dllp_ready
);

  localparam logic [15:0] LAT_LIMIT  = 16'(ACK_LATENCY - 1);
  localparam logic [7:0]  COAL_LIMIT = 8'(ACK_COALESCE);
  localparam logic [7:0]  TYPE_ACK   = 8'h00;
  localparam logic [7:0]  TYPE_NAK   = 8'h10;

  logic [11:0] next_rcv_seq;
  logic        ack_pending;
  logic [7:0]  unacked_cnt;
  logic [15:0] ack_timer;
  logic        force_ack;
  logic        nak_pending;
  logic        nak_scheduled;

  logic [11:0] seq_diff;
  logic [11:0] ack_seq;
  logic        tlp_good;
  logic        tlp_dup;
  logic        tlp_bad;
  logic        slot_free;
  logic        ack_urgent;
  logic        load_nak;
  logic        load_ack;
  logic        load_fc;
  logic        load_acknak;

  // Classify the strobed TLP against the current NEXT_RCV_SEQ.
  // A distance of 1..2048 behind the expected number is a replayed duplicate;
  // anything further is treated as "ahead", meaning a TLP was lost.
  always_comb begin
    seq_diff = next_rcv_seq - rx_tlp_seq;
    tlp_good = 1'b0;
    tlp_dup  = 1'b0;
    tlp_bad  = 1'b0;
    if (rx_tlp_valid) begin
      if (!rx_tlp_lcrc_ok) begin
        tlp_bad = 1'b1;
      end else if (seq_diff == 12'd0) begin
        tlp_good = 1'b1;
      end else if (seq_diff <= 12'd2048) begin
        tlp_dup = 1'b1;
      end else begin
        tlp_bad = 1'b1;
      end
    end
  end

  // Output slot arbitration: Nak beats urgent Ack beats UpdateFC.
  always_comb begin
    ack_seq     = next_rcv_seq - 12'd1;
    slot_free   = !dllp_valid || dllp_ready;
    ack_urgent  = ack_pending && ((ack_timer >= LAT_LIMIT) ||
                                  (unacked_cnt >= COAL_LIMIT) || force_ack);
    load_nak    = slot_free && nak_pending;
    load_ack    = slot_free && !nak_pending && ack_urgent;
    load_fc     = slot_free && !nak_pending && !ack_urgent && fc_req_valid;
    load_acknak = load_nak || load_ack;
  end

  // Sequence/ack bookkeeping and the output slot register. A received TLP in
  // the same cycle as an Ack/Nak load takes precedence over the load's clears,
  // so a fresh accept always leaves one unacked TLP behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_rcv_seq  <= 12'd0;
      ack_pending   <= 1'b0;
      unacked_cnt   <= 8'd0;
      ack_timer     <= 16'd0;
      force_ack     <= 1'b0;
      nak_pending   <= 1'b0;
      nak_scheduled <= 1'b0;
      rx_tlp_accept <= 1'b0;
      rx_tlp_drop   <= 1'b0;
      fc_req_ready  <= 1'b0;
      dllp_valid    <= 1'b0;
      dllp          <= 32'h0;
    end else if (!dl_active) begin
      next_rcv_seq  <= 12'd0;
      ack_pending   <= 1'b0;
      unacked_cnt   <= 8'd0;
      ack_timer     <= 16'd0;
      force_ack     <= 1'b0;
      nak_pending   <= 1'b0;
      nak_scheduled <= 1'b0;
      rx_tlp_accept <= 1'b0;
      rx_tlp_drop   <= 1'b0;
      fc_req_ready  <= 1'b0;
      dllp_valid    <= 1'b0;
      dllp          <= 32'h0;
    end else begin
      rx_tlp_accept <= tlp_good;
      rx_tlp_drop   <= tlp_dup || tlp_bad;
      fc_req_ready  <= load_fc;

      if (tlp_good) begin
        next_rcv_seq <= next_rcv_seq + 12'd1;
      end

      if (tlp_good) begin
        nak_scheduled <= 1'b0;
      end else if (tlp_bad) begin
        nak_scheduled <= 1'b1;
      end

      if (tlp_bad && !nak_scheduled) begin
        nak_pending <= 1'b1;
      end else if (load_nak) begin
        nak_pending <= 1'b0;
      end

      if (tlp_good || tlp_dup) begin
        ack_pending <= 1'b1;
      end else if (load_acknak) begin
        ack_pending <= 1'b0;
      end

      if (tlp_dup) begin
        force_ack <= 1'b1;
      end else if (load_acknak) begin
        force_ack <= 1'b0;
      end

      if (load_acknak) begin
        unacked_cnt <= tlp_good ? 8'd1 : 8'd0;
      end else if (tlp_good && (unacked_cnt != 8'hFF)) begin
        unacked_cnt <= unacked_cnt + 8'd1;
      end

      if (load_acknak || !ack_pending) begin
        ack_timer <= 16'd0;
      end else if (ack_timer != 16'hFFFF) begin
        ack_timer <= ack_timer + 16'd1;
      end

      if (load_nak) begin
        dllp_valid <= 1'b1;
        dllp       <= {TYPE_NAK, 12'h000, ack_seq};
      end else if (load_ack) begin
        dllp_valid <= 1'b1;
        dllp       <= {TYPE_ACK, 12'h000, ack_seq};
      end else if (load_fc) begin
        dllp_valid <= 1'b1;
        dllp       <= fc_req_dllp;
      end else if (slot_free) begin
        dllp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rx_ack_nak_scheduler.md
# rx_ack_nak_scheduler

Sequences the receive-side Data Link Layer: it owns NEXT_RCV_SEQ, classifies each received TLP (good, duplicate, bad/lost), and decides accept/drop. It schedules Ack/Nak DLLPs with an ack-latency timer and coalescing, and arbitrates a single outbound DLLP slot between Ack/Nak and Transaction-Layer UpdateFC requests. It sits between the RX data-link datapath (LCRC/sequence extraction) and the DLLP transmit path toward the Physical Layer.

## Interface
- ACK_LATENCY, 64: cycles a pending Ack may wait before it becomes urgent (1..65535).
- ACK_COALESCE, 8: count of accepted-but-unacked TLPs that makes an Ack urgent (1..255).
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  link in DL_Active; 0 clears sequence state and suppresses DLLPs.
- rx_tlp_valid  in  1  one-cycle strobe: TLP fully received, check results valid.
- rx_tlp_lcrc_ok  in  1  LCRC check passed.
- rx_tlp_seq  in  12  TLP sequence number.
- rx_tlp_accept  out  1  one-cycle pulse: forward TLP to Transaction Layer.
- rx_tlp_drop  out  1  one-cycle pulse: discard TLP.
- fc_req_valid  in  1  UpdateFC DLLP pending.
- fc_req_dllp  in  32  UpdateFC DLLP body.
- fc_req_ready  out  1  one-cycle pulse: fc_req_dllp taken into output slot.
- dllp_valid  out  1  output DLLP valid.
- dllp  out  32  output DLLP body.
- dllp_ready  in  1  downstream takes dllp when dllp_valid && dllp_ready.

## Operation
- Ack/Nak format: dllp[31:24] = 8'h00 Ack / 8'h10 Nak; [23:12] = 0; [11:0] = (NEXT_RCV_SEQ − 1) mod 4096, sampled when loaded.
- State: NEXT_RCV_SEQ[11:0], ack_pending, unacked_cnt[7:0] (saturating), ack_timer[15:0], force_ack, nak_pending, nak_scheduled.
- Classification on rx_tlp_valid, with d = (NEXT_RCV_SEQ − rx_tlp_seq) mod 4096:
  - !lcrc_ok: drop. If !nak_scheduled, set nak_scheduled and nak_pending.
  - lcrc_ok, d == 0: accept. NEXT_RCV_SEQ++ (4095→0), clear nak_scheduled, set ack_pending, unacked_cnt++.
  - lcrc_ok, 1 ≤ d ≤ 2048 (duplicate): drop and set force_ack. ack_pending is set so the Ack repeats the current seq.
  - lcrc_ok, otherwise (ahead, lost TLP): drop. If !nak_scheduled, set nak_scheduled and nak_pending.
- ack_urgent = ack_pending && (ack_timer ≥ ACK_LATENCY−1 || unacked_cnt ≥ ACK_COALESCE || force_ack).
- ack_timer: holds 0 while !ack_pending; increments by 1 per cycle while ack_pending; saturates.
- Output slot is free when !dllp_valid || dllp_ready. When free, load by priority:
  - 1: nak_pending → Nak.
  - 2: ack_urgent → Ack.
  - 3: fc_req_valid → fc_req_dllp, and pulse fc_req_ready.
  - If none apply, dllp_valid drops after the handshake.
- Loading a Nak clears nak_pending, ack_pending, force_ack, unacked_cnt and ack_timer; nak_scheduled stays set.
- Loading an Ack clears ack_pending, force_ack, unacked_cnt and ack_timer.
- If an accept occurs in the same cycle as an Ack/Nak load, the new accept wins: ack_pending = 1, unacked_cnt = 1, timer = 0.
- dl_active = 0: synchronous clear of all state and outputs (NEXT_RCV_SEQ = 0). rx_tlp_valid is ignored. No fc_req_ready.

## Timing
- Reset values: rx_tlp_accept, rx_tlp_drop, fc_req_ready, dllp_valid = 0; dllp = 32'h0. Internal state is all 0.
- rx_tlp_valid at edge N → accept/drop pulse and updated NEXT_RCV_SEQ / flags visible after edge N+1.
- Slot loaded at edge M → dllp_valid = 1 after M. dllp is stable and held until the dllp_ready handshake. Back-to-back loads are allowed on the handshake cycle.
- Earliest Nak: dllp_valid after edge N+2 when the bad TLP is strobed at N and the slot is free.
- With ACK_COALESCE unreached, an Ack is loaded ACK_LATENCY cycles after ack_pending rises.
- rx_tlp_valid may assert every cycle; each strobe is classified against the already-updated NEXT_RCV_SEQ.
- reset_n asserted mid-transfer: dllp_valid drops immediately (asynchronous), with no partial state retained.

## Test plan
- In-order TLPs seq 0..7, ACK_COALESCE=8, dllp_ready=1 → 8 accept pulses. One Ack with dllp = 32'h0000_0007 appears one cycle after the 8th accept.
- Single TLP seq 0, no further traffic, ACK_LATENCY=64 → Ack 32'h0000_0000 loaded 64 cycles after accept. No earlier DLLP.
- Strobes: seq 0 good, seq 1 bad LCRC, seq 2 good (ahead), seq 1 good → accept, drop, drop, accept. Exactly one Nak 32'h1000_0000, then NEXT_RCV_SEQ = 2.
- NEXT_RCV_SEQ = 4095, TLP seq 4095 then seq 0 → both accepted, wrap to 0. Then a duplicate seq 4095 → drop and immediate Ack 32'h0000_0000.
- fc_req_valid held with dllp_ready=0 while a Nak is pending → Nak is held in the slot first. fc_req_ready pulses only on the handshake cycle after the Nak is taken. fc_req_dllp then appears unchanged.
- reset_n pulsed low while dllp_valid=1 → all outputs 0 asynchronously. After release, NEXT_RCV_SEQ = 0 and a seq 0 TLP is accepted.
